// File: rtl/rv32i_types.sv
// Shared types for the reorder-buffer commit controller.
package rv32i_types;

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        HALT
    } rob_ctrl_state_t;

    // Why a retired run ended early: normal cap, redirect, halt, or both.
    typedef enum logic [1:0] {
        STOP_NONE,
        STOP_FLUSH,
        STOP_HALT,
        STOP_HALT_FLUSH
    } rob_stop_t;

endpackage

// File: rtl/rob_commit_count.sv
// Combinational run-length finder: counts consecutive ready entries from the head,
// capped by commit width and occupancy, ending inclusively at a mispredict or halt.
module rob_commit_count
    import rv32i_types::*;
#(
    parameter int size         = 8,
    parameter int commit_width = 2
) (
    input  logic [$clog2(size)-1:0]       front_tag,
    input  logic [$clog2(size):0]         occupancy,
    input  logic [size-1:0]               entry_rdy,
    input  logic [size-1:0]               entry_mispred,
    input  logic [size-1:0]               entry_halt,
    output logic [$clog2(commit_width):0] count,
    output rob_stop_t                     stop,
    output logic [$clog2(size)-1:0]       stop_tag
);
    localparam int TW = $clog2(size);
    localparam int CW = $clog2(commit_width) + 1;

    logic          alive;
    logic [TW-1:0] tag;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        count    = '0;
        stop     = STOP_NONE;
        stop_tag = '0;
        alive    = 1'b1;
        tag      = '0;
        for (int i = 0; i < commit_width; i++) begin
            tag = front_tag + TW'(i);
            if (alive && (i < int'(occupancy)) && entry_rdy[tag]) begin
                count = count + CW'(1);
                if (entry_mispred[tag] || entry_halt[tag]) begin
                    alive    = 1'b0;
                    stop_tag = tag;
                    if (entry_halt[tag])
                        stop = entry_mispred[tag] ? STOP_HALT_FLUSH : STOP_HALT;
                    else
                        stop = STOP_FLUSH;
                end
            end else begin
                alive = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer head/tail bookkeeping with in-order multi-entry retirement,
// mispredict redirect with a one-cycle recovery bubble, and halt detection.
module rob_commit_ctrl
    import rv32i_types::*;
#(
    parameter int size         = 8,
    parameter int commit_width = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq,
    input  logic [size-1:0]               entry_rdy,
    input  logic [size-1:0]               entry_mispred,
    input  logic [size-1:0]               entry_halt,
    input  logic [31:0]                   entry_target [size],
    output logic                          commit,
    output logic [$clog2(commit_width):0] num_deq,
    output logic [$clog2(size)-1:0]       front_tag,
    output logic [$clog2(size)-1:0]       rear_tag,
    output logic                          full,
    output logic                          empty,
    output logic                          flush_valid,
    output logic [31:0]                   flush_pc,
    output logic                          halted,
    output logic                          overflow
);
    localparam int TW = $clog2(size);
    localparam int OW = TW + 1;
    localparam int CW = $clog2(commit_width) + 1;

    rob_ctrl_state_t state_q, state_d;
    logic [TW-1:0]   front_q, front_d, rear_q, rear_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            overflow_q, overflow_d;
    logic            enq_ok;

    logic [CW-1:0]   run_len;
    rob_stop_t       stop;
    logic [TW-1:0]   stop_tag;

    rob_commit_count #(
        .size         (size),
        .commit_width (commit_width)
    ) u_count (
        .front_tag     (front_q),
        .occupancy     (occ_q),
        .entry_rdy     (entry_rdy),
        .entry_mispred (entry_mispred),
        .entry_halt    (entry_halt),
        .count         (run_len),
        .stop          (stop),
        .stop_tag      (stop_tag)
    );

    assign full      = (occ_q == OW'(size));
    assign empty     = (occ_q == '0);
    assign front_tag = front_q;
    assign rear_tag  = rear_q;
    assign halted    = (state_q == HALT);
    assign overflow  = overflow_q;

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        rear_d      = rear_q;
        occ_d       = occ_q;
        overflow_d  = overflow_q;
        enq_ok      = 1'b0;
        commit      = 1'b0;
        num_deq     = '0;
        flush_valid = 1'b0;
        flush_pc    = '0;
        if (!rst) begin
            // Dispatch keeps allocating outside the recovery bubble; a full ROB drops it.
            if (state_q != RECOVER) begin
                enq_ok = enq && !full;
                if (enq && full)
                    overflow_d = 1'b1;
            end
            if (state_q == RUN) begin
                num_deq     = run_len;
                commit      = (run_len != '0);
                flush_valid = (stop == STOP_FLUSH) || (stop == STOP_HALT_FLUSH);
                if (flush_valid)
                    flush_pc = entry_target[stop_tag];
            end
            front_d = front_q + TW'(num_deq);
            rear_d  = rear_q + TW'(enq_ok);
            occ_d   = occ_q + OW'(enq_ok) - OW'(num_deq);
            if (flush_valid) begin
                front_d = '0;
                rear_d  = '0;
                occ_d   = '0;
            end
            case (state_q)
                RUN: begin
                    if ((stop == STOP_HALT) || (stop == STOP_HALT_FLUSH))
                        state_d = HALT;
                    else if (flush_valid)
                        state_d = RECOVER;
                end
                RECOVER: state_d = RUN;
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            front_q    <= '0;
            rear_q     <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            rear_q     <= rear_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed self-checking bench for rob_commit_ctrl with size=8, commit_width=2.
module tb_rob_commit_ctrl;
    import rv32i_types::*;

    localparam int SIZE = 8;
    localparam int CWID = 2;

    logic             clk;
    logic             rst;
    logic             enq;
    logic [SIZE-1:0]  entry_rdy;
    logic [SIZE-1:0]  entry_mispred;
    logic [SIZE-1:0]  entry_halt;
    logic [31:0]      entry_target [SIZE];
    logic             commit;
    logic [1:0]       num_deq;
    logic [2:0]       front_tag;
    logic [2:0]       rear_tag;
    logic             full;
    logic             empty;
    logic             flush_valid;
    logic [31:0]      flush_pc;
    logic             halted;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    rob_commit_ctrl #(
        .size         (SIZE),
        .commit_width (CWID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq           (enq),
        .entry_rdy     (entry_rdy),
        .entry_mispred (entry_mispred),
        .entry_halt    (entry_halt),
        .entry_target  (entry_target),
        .commit        (commit),
        .num_deq       (num_deq),
        .front_tag     (front_tag),
        .rear_tag      (rear_tag),
        .full          (full),
        .empty         (empty),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .halted        (halted),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_entries();
        entry_rdy     = '0;
        entry_mispred = '0;
        entry_halt    = '0;
        for (int i = 0; i < SIZE; i++) entry_target[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq = 1'b0;
        clear_entries();
        step();
        rst = 1'b0;
    endtask

    task automatic enq_n(input int n);
        enq = 1'b1;
        for (int i = 0; i < n; i++) step();
        enq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enq = 1'b0;
        clear_entries();
        step();
        step();

        // Reset state, sampled while rst is still held.
        check("rst_front", front_tag, 0);
        check("rst_rear", rear_tag, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_halted", halted, 0);
        check("rst_commit", commit, 0);
        check("rst_num_deq", num_deq, 0);
        check("rst_flush_valid", flush_valid, 0);
        check("rst_flush_pc", flush_pc, 0);
        rst = 1'b0;

        // Three allocations, head two become ready.
        enq_n(3);
        check("a_rear", rear_tag, 3);
        check("a_empty", empty, 0);
        entry_rdy[0] = 1'b1;
        entry_rdy[1] = 1'b1;
        #1;
        check("a_commit", commit, 1);
        check("a_num_deq", num_deq, 2);
        check("a_front_before", front_tag, 0);
        step();
        check("a_front_after", front_tag, 2);
        clear_entries();
        #1;
        check("a_idle_commit", commit, 0);

        // Four ready entries drain two per cycle, then the empty ROB retires nothing.
        do_reset();
        enq_n(4);
        entry_rdy[3:0] = 4'hf;
        #1;
        check("b_num_deq0", num_deq, 2);
        step();
        check("b_front1", front_tag, 2);
        check("b_num_deq1", num_deq, 2);
        step();
        check("b_front2", front_tag, 4);
        check("b_empty", empty, 1);
        check("b_empty_commit", commit, 0);
        check("b_empty_num_deq", num_deq, 0);

        // Mispredict at tag 1 ends the run inclusively and redirects.
        do_reset();
        enq_n(3);
        entry_rdy[2:0]   = 3'b111;
        entry_mispred[1] = 1'b1;
        entry_target[1]  = 32'h80;
        #1;
        check("c_num_deq", num_deq, 2);
        check("c_flush_valid", flush_valid, 1);
        check("c_flush_pc", flush_pc, 32'h80);
        step();
        clear_entries();
        enq = 1'b1;
        #1;
        check("c_front_zero", front_tag, 0);
        check("c_rear_zero", rear_tag, 0);
        check("c_empty", empty, 1);
        check("c_flush_once", flush_valid, 0);
        step();
        check("c_recover_enq_ignored", rear_tag, 0);
        check("c_recover_no_overflow", overflow, 0);
        step();
        enq = 1'b0;
        check("c_run_enq_taken", rear_tag, 1);

        // Fill to capacity, overflow on a ninth enq, then retire+enq while full.
        do_reset();
        enq_n(8);
        check("d_full", full, 1);
        check("d_rear_wrap", rear_tag, 0);
        check("d_overflow_clear", overflow, 0);
        enq_n(1);
        check("d_rear_unchanged", rear_tag, 0);
        check("d_overflow", overflow, 1);
        entry_rdy[0] = 1'b1;
        enq = 1'b1;
        #1;
        check("d_retire_one", num_deq, 1);
        step();
        enq = 1'b0;
        clear_entries();
        check("d_front_adv", front_tag, 1);
        check("d_enq_ignored_rear", rear_tag, 0);
        check("d_not_full", full, 0);
        check("d_overflow_sticky", overflow, 1);

        // Halt at the head stops all further retirement until reset.
        do_reset();
        enq_n(3);
        entry_rdy[1:0] = 2'b11;
        entry_halt[0]  = 1'b1;
        #1;
        check("e_num_deq", num_deq, 1);
        check("e_no_flush", flush_valid, 0);
        step();
        entry_rdy[2] = 1'b1;
        #1;
        check("e_halted", halted, 1);
        check("e_front", front_tag, 1);
        check("e_commit_blocked", commit, 0);
        check("e_num_deq_blocked", num_deq, 0);
        step();
        check("e_still_halted", halted, 1);
        check("e_front_held", front_tag, 1);
        do_reset();
        check("e_rst_clears_halt", halted, 0);

        // Mispredicted halt: redirect fires, then the controller halts.
        enq_n(2);
        entry_rdy[1:0]   = 2'b11;
        entry_mispred[0] = 1'b1;
        entry_halt[0]    = 1'b1;
        entry_target[0]  = 32'h1234;
        #1;
        check("f_flush_valid", flush_valid, 1);
        check("f_flush_pc", flush_pc, 32'h1234);
        check("f_num_deq", num_deq, 1);
        step();
        check("f_halted", halted, 1);
        check("f_commit_blocked", commit, 0);

        // Reset in the recovery bubble wins over everything else.
        do_reset();
        enq_n(4);
        entry_rdy[0]     = 1'b1;
        entry_mispred[0] = 1'b1;
        entry_target[0]  = 32'h40;
        #1;
        check("g_flush", flush_valid, 1);
        step();
        clear_entries();
        rst            = 1'b1;
        enq            = 1'b1;
        entry_rdy[3:0] = 4'hf;
        #1;
        check("g_rst_commit", commit, 0);
        check("g_rst_num_deq", num_deq, 0);
        check("g_rst_flush", flush_valid, 0);
        step();
        check("g_front", front_tag, 0);
        check("g_rear", rear_tag, 0);
        check("g_empty", empty, 1);
        check("g_full", full, 0);
        check("g_overflow", overflow, 0);
        check("g_halted", halted, 0);
        rst = 1'b0;
        clear_entries();
        step();
        enq = 1'b0;
        check("g_run_after_rst", rear_tag, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
